result_buffer: RTL and testbench

Write-side buffer fed by the ALU/buffer demultiplexer. It captures the 32-bit words the demultiplexer routes to its buffer output (op = 1), together with a destination address. It queues them in a small FIFO and drains them one per handshake into the data-memory write port. Upstream production and memory acceptance are decoupled, so the datapath never stalls on a single busy memory cycle.

---
 rtl/jericalla_pkg.sv | 20 ++
 rtl/result_buffer_mem.sv | 27 ++
 rtl/result_buffer.sv | 134 +++++++++++++
 tb/tb_result_buffer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/jericalla_pkg.sv
// Shared datapath constants and types for the demux / result buffer / memory stage.
package jericalla_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  // One queued memory write: destination address plus data word.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  // Occupancy of the result buffer.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

endpackage

// File: rtl/result_buffer_mem.sv
// DEPTH x W register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset; validity is tracked by the controller.
module result_buffer_mem #(
  parameter int unsigned W     = 37,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [PW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write the addressed entry on an accepted push.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/result_buffer.sv
// Write-side FIFO between the ALU/buffer demux and the data-memory write port.
// Handshaked on both sides; all status outputs come straight from registers.
module result_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        mem_data,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  input  logic                     flush,
  input  logic                     clr_ovf,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  import jericalla_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = ADDR_W + DATA_W;

  occ_e          state, state_n;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q, count_n;
  logic          ovf_q;
  logic          push, pop, drop;
  logic [EW-1:0] head;

  assign in_ready  = (state != OCC_FULL);
  assign mem_valid = (state != OCC_EMPTY);
  assign count     = count_q;
  assign overflow  = ovf_q;

  // Flush discards the whole cycle's traffic, including a would-be overflow.
  assign push = in_valid &&  in_ready && !flush;
  assign pop  = mem_valid && mem_ready && !flush;
  assign drop = in_valid && !in_ready && !flush;

  result_buffer_mem #(
    .W     (EW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({in_addr, in_data}),
    .raddr (rd_ptr),
    .rdata (head)
  );

  assign mem_addr = head[EW-1:DATA_W];
  assign mem_data = head[DATA_W-1:0];

  // Next occupancy state and count from the push/pop pair.
  always_comb begin
    state_n = state;
    count_n = count_q;
    if (flush) begin
      state_n = OCC_EMPTY;
      count_n = '0;
    end else begin
      if (push && !pop) begin
        count_n = count_q + CW'(1);
      end else if (pop && !push) begin
        count_n = count_q - CW'(1);
      end
      unique case (state)
        OCC_EMPTY: begin
          if (push) begin
            state_n = OCC_PARTIAL;
          end
        end
        OCC_PARTIAL: begin
          if (push && !pop && count_q == CW'(DEPTH - 1)) begin
            state_n = OCC_FULL;
          end else if (pop && !push && count_q == CW'(1)) begin
            state_n = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            state_n = OCC_PARTIAL;
          end
        end
        default: state_n = OCC_EMPTY;
      endcase
    end
  end

  // Occupancy state, count and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= OCC_EMPTY;
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
    end else begin
      state   <= state_n;
      count_q <= count_n;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
      end
    end
  end

  // Sticky overflow: a dropped push wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_result_buffer.sv
// Self-checking bench for result_buffer: directed scenarios then random traffic
// against a queue-based reference model.
module tb_result_buffer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] in_data;
  logic [ADDR_W-1:0] in_addr;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] mem_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic              mem_ready;
  logic              flush;
  logic              clr_ovf;
  logic [2:0]        count;
  logic              overflow;

  result_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_data  (mem_data),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .flush     (flush),
    .clr_ovf   (clr_ovf),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: ordered queue of {addr, data} plus sticky overflow bit.
  logic [ADDR_W+DATA_W-1:0] q[$];
  logic                     m_ovf;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_count"},     64'(count),     64'(q.size()));
    chk({tag, "_mem_valid"}, 64'(mem_valid), 64'(q.size() != 0));
    chk({tag, "_in_ready"},  64'(in_ready),  64'(q.size() < DEPTH));
    chk({tag, "_overflow"},  64'(overflow),  64'(m_ovf));
    if (q.size() != 0) begin
      chk({tag, "_head"}, 64'({mem_addr, mem_data}), 64'(q[0]));
    end
  endtask

  // Apply one cycle of inputs (called at a falling edge), advance the model,
  // then check all outputs at the next falling edge.
  task automatic step(input logic v, input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a,
                      input logic r, input logic f, input logic c, input string tag);
    in_valid  = v;
    in_data   = d;
    in_addr   = a;
    mem_ready = r;
    flush     = f;
    clr_ovf   = c;
    if (f) begin
      q.delete();
      if (c) m_ovf = 1'b0;
    end else begin
      automatic bit was_full  = (q.size() == DEPTH);
      automatic bit was_empty = (q.size() == 0);
      if (v && was_full)   m_ovf = 1'b1;
      else if (c)          m_ovf = 1'b0;
      if (r && !was_empty) void'(q.pop_front());
      if (v && !was_full)  q.push_back({a, d});
    end
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    q.delete();
    m_ovf     = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_addr   = '0;
    mem_ready = 1'b0;
    flush     = 1'b0;
    clr_ovf   = 1'b0;

    // Reset state
    #1;
    check_all("reset");
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single push into empty buffer, visible next cycle
    step(1'b1, 32'hDEADBEEF, 5'd5, 1'b0, 1'b0, 1'b0, "t1");
    chk("t1_data",  64'(mem_data),  64'hDEADBEEF);
    chk("t1_addr",  64'(mem_addr),  64'd5);
    chk("t1_count", 64'(count),     64'd1);
    chk("t1_valid", 64'(mem_valid), 64'd1);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, "t1_flush");

    // Fill, overflow, drain in order
    for (int unsigned i = 1; i <= 4; i++)
      step(1'b1, DATA_W'(i), ADDR_W'(i), 1'b0, 1'b0, 1'b0, "t2_fill");
    chk("t2_count_full", 64'(count),    64'd4);
    chk("t2_not_ready",  64'(in_ready), 64'd0);
    step(1'b1, 32'h5, 5'd5, 1'b0, 1'b0, 1'b0, "t2_ovf");
    chk("t2_overflow", 64'(overflow), 64'd1);
    for (int unsigned i = 1; i <= 4; i++) begin
      chk("t2_drain", 64'(mem_data), 64'(i));
      step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "t2_pop");
    end
    chk("t2_empty", 64'(mem_valid), 64'd0);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "t2_clr");

    // Streaming: one push and one pop per cycle
    for (int unsigned i = 0; i < 16; i++) begin
      if (i > 0) begin
        chk("t3_stream_data",  64'(mem_data), 64'(32'h10 + i - 1));
        chk("t3_stream_count", 64'(count),    64'd1);
      end
      step(1'b1, 32'h10 + DATA_W'(i), ADDR_W'(i), 1'b1, 1'b0, 1'b0, "t3");
    end
    chk("t3_last", 64'(mem_data), 64'h1F);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "t3_tail");

    // Full with simultaneous push and pop: only the pop happens
    for (int unsigned i = 0; i < 4; i++)
      step(1'b1, 32'hA0 + DATA_W'(i), ADDR_W'(i), 1'b0, 1'b0, 1'b0, "t4_fill");
    step(1'b1, 32'hAA, 5'd9, 1'b1, 1'b0, 1'b0, "t4_both");
    chk("t4_count", 64'(count),    64'd3);
    chk("t4_ovf",   64'(overflow), 64'd1);
    step(1'b1, 32'hBB, 5'd10, 1'b0, 1'b0, 1'b0, "t4_accept");
    chk("t4_count4", 64'(count), 64'd4);

    // Flush with in_valid at count 3; overflow untouched; then clear
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, "t5_pop");
    step(1'b1, 32'hCC, 5'd1, 1'b0, 1'b1, 1'b0, "t5_flush");
    chk("t5_count", 64'(count),     64'd0);
    chk("t5_valid", 64'(mem_valid), 64'd0);
    chk("t5_ovf",   64'(overflow),  64'd1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "t5_clr");
    chk("t5_ovf_clr", 64'(overflow), 64'd0);

    // Asynchronous reset between edges
    step(1'b1, 32'h61, 5'd1, 1'b0, 1'b0, 1'b0, "t6_p1");
    step(1'b1, 32'h62, 5'd2, 1'b0, 1'b0, 1'b0, "t6_p2");
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    chk("t6_rst_count", 64'(count),     64'd0);
    chk("t6_rst_valid", 64'(mem_valid), 64'd0);
    chk("t6_rst_ready", 64'(in_ready),  64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h77, 5'd3, 1'b0, 1'b0, 1'b0, "t6_resume");
    chk("t6_resume_data", 64'(mem_data), 64'h77);
    step(1'b1, 32'h78, 5'd4, 1'b1, 1'b0, 1'b0, "t6_resume2");
    chk("t6_resume2_data", 64'(mem_data), 64'h78);

    // Random traffic against the model
    for (int unsigned n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 1)), DATA_W'($urandom), ADDR_W'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 7) == 0), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
